// File: rtl/lsu_mem_stage_if.sv
// Request/response handshake bundle between the execute stage and lsu_mem_stage.
interface lsu_mem_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// Single-outstanding load/store unit: optional latency wait, one-cycle DRAM access, lane extract/replicate.
// Define LSU_MISALIGN_CHECK_EN to turn misaligned half/word accesses into error responses.
module lsu_mem_stage #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_mem_stage_if.slave bus,
  output logic        dram_en,
  output logic        dram_wen,
  output logic [31:0] dram_addr,
  output logic [31:0] dram_wdata,
  output logic [3:0]  dram_wmask,
  input  logic [31:0] dram_rdata
);
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  typedef struct packed {
    logic        wen;
    logic [29:0] word;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
  } req_t;

  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      state;
  req_t        req;
  logic [3:0]  cnt;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        acc_err, in_access;
  logic [1:0]  acc_off;
  logic [31:0] shifted, ld_data;

  assign bus.req_ready  = rst_n && (state == IDLE);
  assign bus.resp_valid = rsp_valid;
  assign bus.resp_rdata = rsp_rdata;
  assign bus.resp_err   = rsp_err;

  // Error classification and effective byte offset, decided at acceptance.
  always_comb begin
    acc_off = bus.req_addr[1:0];
    acc_err = 1'b0;
    unique case (bus.req_size)
      2'b00: ;
      2'b01: begin
`ifdef LSU_MISALIGN_CHECK_EN
        acc_err = bus.req_addr[0];
`else
        acc_off = {bus.req_addr[1], 1'b0};
`endif
      end
      2'b10: begin
`ifdef LSU_MISALIGN_CHECK_EN
        acc_err = |bus.req_addr[1:0];
`else
        acc_off = 2'b00;
`endif
      end
      default: acc_err = 1'b1;
    endcase
  end

  // rst_n gating keeps a store from committing if reset lands in ACCESS.
  assign in_access = rst_n && (state == ACCESS);
  assign dram_en   = in_access;
  assign dram_wen  = in_access & req.wen;
  assign dram_addr = in_access ? {req.word, 2'b00} : 32'h0;

  always_comb begin
    dram_wmask = 4'b0000;
    dram_wdata = 32'h0;
    if (in_access) begin
      unique case (req.size)
        2'b00: begin
          dram_wmask = 4'b0001 << req.off;
          dram_wdata = {4{req.wdata[7:0]}};
        end
        2'b01: begin
          dram_wmask = 4'b0011 << req.off;
          dram_wdata = {2{req.wdata[15:0]}};
        end
        default: begin
          dram_wmask = 4'b1111;
          dram_wdata = req.wdata;
        end
      endcase
    end
  end

  always_comb begin
    shifted = dram_rdata >> {req.off, 3'b000};
    ld_data = shifted;
    unique case (req.size)
      2'b00:   ld_data = {{24{~req.uns & shifted[7]}}, shifted[7:0]};
      2'b01:   ld_data = {{16{~req.uns & shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req       <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.req_valid) begin
          req.wen   <= bus.req_wen;
          req.word  <= bus.req_addr[31:2];
          req.wdata <= bus.req_wdata;
          req.size  <= bus.req_size;
          req.uns   <= bus.req_unsigned;
          req.off   <= acc_off;
          cnt       <= CNT_INIT;
          if (acc_err) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else if (LATENCY > 0) begin
            state <= WAIT;
          end else begin
            state <= ACCESS;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= ACCESS;
          else             cnt   <= cnt - 4'd1;
        end
        ACCESS: begin
          rsp_rdata <= req.wen ? 32'h0 : ld_data;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (bus.resp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage with LATENCY=2 and a small word-addressed DRAM model.
module tb_lsu_mem_stage;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dram_en, dram_wen;
  logic [31:0] dram_addr, dram_wdata, dram_rdata;
  logic [3:0]  dram_wmask;
  logic [31:0] mem [0:15] = '{default: 32'h0};
  int          write_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  lsu_mem_stage_if bus();

  lsu_mem_stage #(.LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dram_en    (dram_en),
    .dram_wen   (dram_wen),
    .dram_addr  (dram_addr),
    .dram_wdata (dram_wdata),
    .dram_wmask (dram_wmask),
    .dram_rdata (dram_rdata)
  );

  always #5 clk = ~clk;

  assign dram_rdata = mem[dram_addr[5:2]];

  always @(posedge clk) begin
    if (dram_en && dram_wen) begin
      for (int b = 0; b < 4; b++)
        if (dram_wmask[b]) mem[dram_addr[5:2]][b*8 +: 8] <= dram_wdata[b*8 +: 8];
      write_cnt <= write_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input logic [3:0] exp_mask, input logic [31:0] exp_wdata, input int hold);
    int k, wt, en_cnt, en_cyc;
    logic stray;
    logic [31:0] snap_d;
    logic snap_e;
    exp_t e;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    wt = 0;
    while (!bus.req_ready && wt < 20) begin @(negedge clk); wt++; end
    chk({tag, ":req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_wen = wen; bus.req_addr = addr; bus.req_wdata = wdata;
    bus.req_size = size; bus.req_unsigned = uns; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    k = 0; en_cnt = 0; en_cyc = -1; stray = 1'b0;
    do begin
      @(negedge clk);
      k++;
      if (dram_en) begin
        en_cnt++;
        en_cyc = k;
        chk({tag, ":dram_wen"}, 32'(dram_wen), 32'(wen));
        chk({tag, ":dram_addr"}, dram_addr, {addr[31:2], 2'b00});
        if (wen) begin
          chk({tag, ":dram_wmask"}, 32'(dram_wmask), 32'(exp_mask));
          chk({tag, ":dram_wdata"}, dram_wdata, exp_wdata);
        end
      end else begin
        stray |= dram_wen | (|dram_addr) | (|dram_wdata) | (|dram_wmask);
      end
    end while (!bus.resp_valid && k < 40);
    if (!bus.resp_valid) begin
      chk({tag, ":resp_timeout"}, 32'd0, 32'd1);
      void'(sb_q.pop_front());
      return;
    end
    chk({tag, ":dram_idle_zero"}, 32'(stray), 32'd0);
    chk({tag, ":resp_cycle"}, 32'(k), exp_err ? 32'd1 : 32'(LAT + 2));
    chk({tag, ":access_count"}, 32'(en_cnt), exp_err ? 32'd0 : 32'd1);
    chk({tag, ":access_cycle"}, 32'(en_cyc), exp_err ? 32'hFFFF_FFFF : 32'(LAT + 1));
    snap_d = bus.resp_rdata;
    snap_e = bus.resp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ":hold_valid"}, 32'(bus.resp_valid), 32'd1);
      chk({tag, ":hold_rdata"}, bus.resp_rdata, snap_d);
      chk({tag, ":hold_err"}, 32'(bus.resp_err), 32'(snap_e));
      chk({tag, ":hold_req_ready"}, 32'(bus.req_ready), 32'd0);
    end
    if (sb_q.size() == 0) begin
      chk({tag, ":sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ":rdata"}, bus.resp_rdata, e.rdata);
      chk({tag, ":err"}, 32'(bus.resp_err), 32'(e.err));
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    chk({tag, ":post_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, ":post_req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic reset_in_wait();
    int w0;
    @(negedge clk);
    w0 = write_cnt;
    bus.req_wen = 1'b1; bus.req_addr = 32'h8000_0010; bus.req_wdata = 32'h5555_5555;
    bus.req_size = 2'b10; bus.req_unsigned = 1'b0; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst_wait:dram_en", 32'(dram_en), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wait:write_cnt", 32'(write_cnt), 32'(w0));
    chk("rst_wait:mem", mem[4], 32'h0);
    chk("rst_wait:req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_wait:resp_valid", 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_size = 2'b00; bus.req_unsigned = 1'b0; bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst:dram_en_low", 32'(dram_en), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst:req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst:resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst:resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst:resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst:dram_outs", {dram_addr[31:6], dram_en, dram_wen, dram_wmask}, 32'h0);

    do_req("sw",      1, 32'h8000_0004, 32'hDEAD_BEEF, 2'b10, 0, 32'h0, 0, 4'b1111, 32'hDEAD_BEEF, 0);
    do_req("lw",      0, 32'h8000_0004, 32'h0,         2'b10, 0, 32'hDEAD_BEEF, 0, 4'h0, 32'h0, 0);
    do_req("sw_pat",  1, 32'h8000_0008, 32'h80FF_7F01, 2'b10, 0, 32'h0, 0, 4'b1111, 32'h80FF_7F01, 0);
    do_req("lb3",     0, 32'h8000_000B, 32'h0, 2'b00, 0, 32'hFFFF_FF80, 0, 4'h0, 32'h0, 0);
    do_req("lbu3",    0, 32'h8000_000B, 32'h0, 2'b00, 1, 32'h0000_0080, 0, 4'h0, 32'h0, 0);
    do_req("lh2",     0, 32'h8000_000A, 32'h0, 2'b01, 0, 32'hFFFF_80FF, 0, 4'h0, 32'h0, 0);
    do_req("lhu0",    0, 32'h8000_0008, 32'h0, 2'b01, 1, 32'h0000_7F01, 0, 4'h0, 32'h0, 0);
    do_req("sb2",     1, 32'h8000_000E, 32'hFFFF_FFAB, 2'b00, 0, 32'h0, 0, 4'b0100, 32'hABAB_ABAB, 0);
    do_req("sh2",     1, 32'h8000_000E, 32'hCAFE_1234, 2'b01, 0, 32'h0, 0, 4'b1100, 32'h1234_1234, 0);
    do_req("lw_c",    0, 32'h8000_000C, 32'h0, 2'b10, 0, 32'h1234_0000, 0, 4'h0, 32'h0, 0);
    do_req("sw_base", 1, 32'h8000_0000, 32'h0123_4567, 2'b10, 0, 32'h0, 0, 4'b1111, 32'h0123_4567, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    do_req("lw_mis",  0, 32'h8000_0002, 32'h0, 2'b10, 0, 32'h0, 1, 4'h0, 32'h0, 0);
    do_req("lh_mis",  0, 32'h8000_0003, 32'h0, 2'b01, 0, 32'h0, 1, 4'h0, 32'h0, 0);
`else
    do_req("lw_mis",  0, 32'h8000_0002, 32'h0, 2'b10, 0, 32'h0123_4567, 0, 4'h0, 32'h0, 0);
    do_req("lh_mis",  0, 32'h8000_0003, 32'h0, 2'b01, 0, 32'h0000_0123, 0, 4'h0, 32'h0, 0);
`endif
    do_req("size11",  0, 32'h8000_0004, 32'h0, 2'b11, 0, 32'h0, 1, 4'h0, 32'h0, 0);
    do_req("bp_lw",   0, 32'h8000_0004, 32'h0, 2'b10, 0, 32'hDEAD_BEEF, 0, 4'h0, 32'h0, 5);
    do_req("bp_err",  1, 32'h8000_0004, 32'h0, 2'b11, 0, 32'h0, 1, 4'h0, 32'h0, 3);

    reset_in_wait();
    do_req("lw_after_rst", 0, 32'h8000_0010, 32'h0, 2'b10, 0, 32'h0, 0, 4'h0, 32'h0, 0);
    do_req("lw_final",     0, 32'h8000_0004, 32'h0, 2'b10, 0, 32'hDEAD_BEEF, 0, 4'h0, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit that sits between the execute stage and the `DRAM` block. It accepts one memory request at a time over a valid/ready handshake, optionally inserts a programmable wait to model memory latency, and drives `DRAM` for exactly one cycle. For loads it lane-extracts and sign/zero-extends the returned word; for stores it replicates the data across byte lanes and generates the byte mask. It returns a response over a second valid/ready handshake.

## Interface
Parameters:
- `LATENCY`, default 1: wait cycles inserted before the DRAM access cycle; legal range 0..15.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` input, 1 bit: clock; all state changes on the rising edge.
  - `rst_n` input, 1 bit: asynchronous reset, active low.
- Request side:
  - `req_valid` input, 1: request present.
  - `req_ready` output, 1: LSU can accept; high only in IDLE.
  - `req_wen` input, 1: 1 = store, 0 = load.
  - `req_addr` input, 32: byte address.
  - `req_wdata` input, 32: store data, right-aligned.
  - `req_size` input, 2: 00 byte, 01 half, 10 word, 11 illegal.
  - `req_unsigned` input, 1: zero-extend loads when 1.
- Response side:
  - `resp_valid` output, 1: response held until accepted.
  - `resp_ready` input, 1: consumer accepts the response.
  - `resp_rdata` output, 32: extended load data; 0 for stores and errors.
  - `resp_err` output, 1: illegal size, or misalignment (see Configuration).
- DRAM side (connects 1:1 to `DRAM`):
  - `dram_en` output, 1: access enable.
  - `dram_wen` output, 1: write enable.
  - `dram_addr` output, 32: word-aligned address.
  - `dram_wdata` output, 32: lane-replicated store data.
  - `dram_wmask` output, 4: byte mask.
  - `dram_rdata` input, 32: combinational read data, valid in the same cycle as `dram_en`.

## Operation
- States:
  - IDLE → (WAIT if `LATENCY` > 0, else ACCESS) when `req_valid` & `req_ready`. The request fields and the counter (`LATENCY` − 1) are registered.
  - WAIT: decrement the counter; at 0 → ACCESS.
  - ACCESS: `dram_en` = 1 for exactly one cycle; `dram_wen` = `req_wen`. For loads, the extracted `dram_rdata` is registered into `resp_rdata`. → RESP.
  - RESP: `resp_valid` = 1; on `resp_ready` → IDLE.
  - Error requests (illegal size, or misaligned with checking enabled) go IDLE → RESP directly. They set `resp_err` = 1, `resp_rdata` = 0, and generate no DRAM access.
- `dram_addr` = {addr[31:2], 2'b00}.
- Store mask and data:
  - byte: mask = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - half: mask = 4'b0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
  - word: mask = 4'b1111; wdata unchanged.
- Load data: shift `dram_rdata` right by addr[1:0]*8, take the low 8/16/32 bits, then extend with sign or zero per `req_unsigned`.
- Outside ACCESS, `dram_en`, `dram_wen`, `dram_addr`, `dram_wdata` and `dram_wmask` are all 0. This guarantees exactly one DPI write per store.
- Store response: `resp_valid` with `resp_rdata` = 0 and `resp_err` = 0.

## Timing
- Reset values: state IDLE; `req_ready` = 1 once `rst_n` is high; `resp_valid`, `resp_rdata`, `resp_err` = 0; all `dram_*` outputs = 0.
- Cycle 0 is acceptance. The ACCESS cycle is cycle `LATENCY` + 1, and `resp_valid` rises in cycle `LATENCY` + 2.
- Error requests assert `resp_valid` in cycle 1.
- `resp_valid`, `resp_rdata` and `resp_err` are stable while `resp_ready` is low.
- Back-to-back: `req_ready` returns in the cycle after the response is accepted, so there is at least one idle cycle between requests.
- Reset mid-operation: the FSM returns to IDLE asynchronously and the in-flight request is dropped. A store in ACCESS is not committed if `rst_n` is low at the closing edge, because `dram_en` is forced to 0 combinationally.
- Request inputs are ignored while `req_ready` is 0.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined: half accesses with addr[0] = 1, and word accesses with addr[1:0] ≠ 0, are errors (see Operation).
- `LSU_MISALIGN_CHECK_EN` undefined: misaligned low address bits are ignored.
  - half uses addr[1] only.
  - word uses offset 0.
  - `resp_err` is set only for size 11.

## Test plan
- `LATENCY` = 2; sw 0xDEADBEEF to 0x80000004, then lw from the same address → exactly one `dram_en`/`dram_wen` pulse with mask 1111 in cycle 3; load returns 0xDEADBEEF with `resp_valid` in cycle 4.
- Memory word 0x80FF7F01; lb at +3 → 0xFFFFFF80; lbu at +3 → 0x00000080; lh at +2 → 0xFFFF80FF; lhu at +0 → 0x00007F01.
- sb 0xAB to addr offset 2 → `dram_wmask` = 0100, `dram_wdata` = 0xABABABAB; sh 0x1234 at offset 2 → mask 1100, wdata 0x12341234.
- With the macro defined: lw at 0x80000002 → `resp_err` = 1, `resp_rdata` = 0, no `dram_en`, `resp_valid` in cycle 1. Without the macro: the same request reads 0x80000000 with `resp_err` = 0. In both builds, size 11 → `resp_err` = 1.
- `resp_ready` held low for 5 cycles → response fields stable and `req_ready` = 0 throughout; the next request is accepted only after the handshake completes.
- Assert `rst_n` low during WAIT of a store → no DRAM write occurs; after release, `req_ready` = 1 and `resp_valid` = 0.
